// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: request-to-send, odd-parity serialisation
// on device-generated clock edges, line-level acknowledge check and inter-edge watchdog.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 750000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] cmd_byte,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       busy,
    output logic       done,
    output logic       ack_error,
    output logic       timeout_error
);

    localparam int CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] INHIBIT_LOAD = CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LOAD = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_INHIBIT   = 3'd1;
    localparam logic [2:0] S_REQUEST   = 3'd2;
    localparam logic [2:0] S_SHIFT     = 3'd3;
    localparam logic [2:0] S_ACK       = 3'd4;
    localparam logic [2:0] S_WAIT_IDLE = 3'd5;

    logic [2:0]       r_state;
    logic [1:0]       r_clk_sync;
    logic [1:0]       r_data_sync;
    logic             r_clk_prev;
    logic [8:0]       r_shift;
    logic [3:0]       r_bit_cnt;
    logic [CNT_W-1:0] r_cnt;
    logic             r_ack_bad;
    logic             r_clk_oe;
    logic             r_data_oe;
    logic             r_done;
    logic             r_ack_error;
    logic             r_timeout;

    logic w_clk_s;
    logic w_data_s;
    logic w_fe;
    logic w_watch;
    logic w_accept;
    logic w_expire;

    // NOTE: synchronisers reset to 1 so an idle (pulled-up) bus never looks like a falling edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_clk_sync  <= 2'b11;
            r_data_sync <= 2'b11;
            r_clk_prev  <= 1'b1;
        end else begin
            r_clk_sync  <= {r_clk_sync[0], ps2_clk_in};
            r_data_sync <= {r_data_sync[0], ps2_data_in};
            r_clk_prev  <= r_clk_sync[1];
        end
    end

    assign w_clk_s  = r_clk_sync[1];
    assign w_data_s = r_data_sync[1];
    assign w_fe     = r_clk_prev & ~w_clk_s;
    assign w_watch  = (r_state != S_IDLE) && (r_state != S_INHIBIT);
    assign w_accept = cmd_valid & cmd_ready;
    assign w_expire = w_watch && !w_fe && (r_cnt == CNT_ONE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_shift     <= '0;
            r_bit_cnt   <= '0;
            r_cnt       <= '0;
            r_ack_bad   <= 1'b0;
            r_clk_oe    <= 1'b0;
            r_data_oe   <= 1'b0;
            r_done      <= 1'b0;
            r_ack_error <= 1'b0;
            r_timeout   <= 1'b0;
        end else begin
            r_done      <= 1'b0;
            r_ack_error <= 1'b0;
            r_timeout   <= 1'b0;
            if (w_expire) begin
                r_timeout <= 1'b1;
                r_clk_oe  <= 1'b0;
                r_data_oe <= 1'b0;
                r_state   <= S_IDLE;
            end else begin
                if (w_watch) begin
                    r_cnt <= w_fe ? TIMEOUT_LOAD : r_cnt - CNT_ONE;
                end
                case (r_state)
                    S_IDLE: begin
                        r_clk_oe  <= 1'b0;
                        r_data_oe <= 1'b0;
                        if (w_accept) begin
                            r_shift  <= {~^cmd_byte, cmd_byte};
                            r_cnt    <= INHIBIT_LOAD;
                            r_clk_oe <= 1'b1;
                            r_state  <= S_INHIBIT;
                        end
                    end
                    // Start bit goes low one cycle before the clock is released.
                    S_INHIBIT: begin
                        if (r_cnt == CNT_ONE) begin
                            r_data_oe <= 1'b1;
                            r_cnt     <= TIMEOUT_LOAD;
                            r_state   <= S_REQUEST;
                        end else begin
                            r_cnt <= r_cnt - CNT_ONE;
                        end
                    end
                    S_REQUEST: begin
                        r_clk_oe  <= 1'b0;
                        r_bit_cnt <= '0;
                        r_state   <= S_SHIFT;
                    end
                    // Shift register refills with 1s, so the tenth edge drives the released stop bit.
                    S_SHIFT: begin
                        if (w_fe) begin
                            r_data_oe <= ~r_shift[0];
                            r_shift   <= {1'b1, r_shift[8:1]};
                            r_bit_cnt <= r_bit_cnt + 4'd1;
                            if (r_bit_cnt == 4'd9) begin
                                r_state <= S_ACK;
                            end
                        end
                    end
                    S_ACK: begin
                        if (w_fe) begin
                            r_ack_bad <= w_data_s;
                            r_data_oe <= 1'b0;
                            r_state   <= S_WAIT_IDLE;
                        end
                    end
                    S_WAIT_IDLE: begin
                        if (w_clk_s && w_data_s) begin
                            r_done      <= 1'b1;
                            r_ack_error <= r_ack_bad;
                            r_state     <= S_IDLE;
                        end
                    end
                    default: begin
                        r_clk_oe  <= 1'b0;
                        r_data_oe <= 1'b0;
                        r_state   <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign ps2_clk_oe    = r_clk_oe;
    assign ps2_data_oe   = r_data_oe;
    assign busy          = (r_state != S_IDLE);
    assign cmd_ready     = (r_state == S_IDLE) && !r_done && !r_timeout;
    assign done          = r_done;
    assign ack_error     = r_ack_error;
    assign timeout_error = r_timeout;

endmodule
